memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/dmem_ctrl.sv | 83 ++++++++
 rtl/memory_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Purpose : result-source encodings, the memory-stage controller state
//           enum and a small memory-op decode helper. The writeback mux,
//           the hazard unit and the memory stage all import this package.
// Ports   : none (package).
package pipe_pkg;

  // Writeback result selection.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Memory-stage controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  // An instruction touches data memory when it is a load or a store.
  function automatic logic is_mem_op(input logic [1:0] result_src,
                                     input logic       mem_write);
    return (result_src == RES_MEM) || mem_write;
  endfunction

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the memory stage.
// Purpose : IDLE/BUSY/DONE sequencer. A memory op captured into EX/MEM
//           moves the controller to BUSY, where the request is held until
//           the memory acks; the following DONE cycle lets the pipeline
//           advance again, and a new memory op may enter BUSY directly.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           start           - execute presents a non-flushed memory op
//           start_store     - that op is a store
//           ack             - memory acknowledge (only looked at in BUSY)
//           capture         - EX/MEM register may load on this edge
//           busy            - controller is in BUSY (pipeline stall)
//           req, we         - registered memory request / write enable
module dmem_ctrl
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic start_store,
  input  logic ack,
  output logic capture,
  output logic busy,
  output logic req,
  output logic we
);

  mem_state_t state_r;
  mem_state_t next_state_s;
  logic       req_r;
  logic       we_r;
  logic       req_next_s;
  logic       we_next_s;

  // Next-state and next-request decode; req/we are registered so the
  // memory sees flop outputs that cannot glitch during an access.
  always_comb begin
    next_state_s = state_r;
    req_next_s   = 1'b0;
    we_next_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state_s = ST_BUSY;
          req_next_s   = 1'b1;
          we_next_s    = start_store;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ack) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_BUSY;
          req_next_s   = 1'b1;
          we_next_s    = we_r;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      req_r   <= req_next_s;
      we_r    <= we_next_s;
    end
  end

  assign busy    = (state_r == ST_BUSY);
  assign capture = ~busy;
  assign req     = req_r;
  assign we      = we_r;

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the in-order pipeline.
// Purpose : holds the EX/MEM pipeline register, issues data-memory loads
//           and stores through dmem_ctrl, stalls the front of the pipe
//           while an access waits for its ack, and latches load data.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           *_e                  - instruction fields from execute
//           flush_i              - turn the instruction from execute into a bubble
//           *_m                  - registered fields to writeback
//           read_data_m          - last load data returned by memory
//           stall_o              - freeze fetch/decode/execute
//           dmem_*               - data-memory request/response interface
module memory_stage
  import pipe_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write_e,
  input  logic [1:0]         result_src_e,
  input  logic               mem_write_e,
  input  logic [D_WIDTH-1:0] alu_result_e,
  input  logic [D_WIDTH-1:0] write_data_e,
  input  logic [4:0]         rd_e,
  input  logic [D_WIDTH-1:0] pc_plus_4e,
  input  logic               flush_i,
  output logic               reg_write_m,
  output logic [1:0]         result_src_m,
  output logic [4:0]         rd_m,
  output logic [D_WIDTH-1:0] alu_result_m,
  output logic [D_WIDTH-1:0] read_data_m,
  output logic [D_WIDTH-1:0] pc_plus_4m,
  output logic               stall_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [D_WIDTH-1:0] dmem_addr_o,
  output logic [D_WIDTH-1:0] dmem_wdata_o,
  input  logic               dmem_ack_i,
  input  logic [D_WIDTH-1:0] dmem_rdata_i
);

  logic               reg_write_r;
  logic [1:0]         result_src_r;
  logic               mem_write_r;
  logic [D_WIDTH-1:0] alu_result_r;
  logic [D_WIDTH-1:0] write_data_r;
  logic [4:0]         rd_r;
  logic [D_WIDTH-1:0] pc_plus_4_r;
  logic [D_WIDTH-1:0] read_data_r;

  logic start_s;
  logic capture_s;
  logic busy_s;
  logic req_s;
  logic we_s;
  logic load_ack_s;

  // A flushed instruction never starts an access, whatever it decodes as.
  assign start_s = ~flush_i & is_mem_op(result_src_e, mem_write_e);

  dmem_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s),
    .start_store (mem_write_e),
    .ack         (dmem_ack_i),
    .capture     (capture_s),
    .busy        (busy_s),
    .req         (req_s),
    .we          (we_s)
  );

  // EX/MEM pipeline register: loads whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_r  <= 1'b0;
      result_src_r <= RES_ALU;
      mem_write_r  <= 1'b0;
      alu_result_r <= {D_WIDTH{1'b0}};
      write_data_r <= {D_WIDTH{1'b0}};
      rd_r         <= 5'd0;
      pc_plus_4_r  <= {D_WIDTH{1'b0}};
    end else if (capture_s) begin
      // Data fields are taken even for a bubble; only control is killed.
      alu_result_r <= alu_result_e;
      write_data_r <= write_data_e;
      pc_plus_4_r  <= pc_plus_4e;
      if (flush_i) begin
        reg_write_r  <= 1'b0;
        result_src_r <= RES_ALU;
        mem_write_r  <= 1'b0;
        rd_r         <= 5'd0;
      end else begin
        reg_write_r  <= reg_write_e;
        result_src_r <= result_src_e;
        mem_write_r  <= mem_write_e;
        rd_r         <= rd_e;
      end
    end
  end

  // Load data only changes on the ack of a load; stores leave it alone.
  assign load_ack_s = busy_s & dmem_ack_i & ~mem_write_r;

  // Load-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_r <= {D_WIDTH{1'b0}};
    end else if (load_ack_s) begin
      read_data_r <= dmem_rdata_i;
    end
  end

  assign reg_write_m  = reg_write_r;
  assign result_src_m = result_src_r;
  assign rd_m         = rd_r;
  assign alu_result_m = alu_result_r;
  assign pc_plus_4m   = pc_plus_4_r;
  assign read_data_m  = read_data_r;

  assign stall_o      = busy_s;
  assign dmem_req_o   = req_s;
  assign dmem_we_o    = we_s;
  // Address/data are forced to zero outside an access.
  assign dmem_addr_o  = req_s ? alu_result_r : {D_WIDTH{1'b0}};
  assign dmem_wdata_o = req_s ? write_data_r : {D_WIDTH{1'b0}};

endmodule
